// File: rtl/snake_sched_pkg.sv
// Shared definitions for the snake game step scheduler: FSM state encoding,
// difficulty codes and the frames-per-step period selection helper.
package snake_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_PAUSED = 3'd2,
    ST_REQ    = 3'd3,
    ST_FAULT  = 3'd4
  } sched_state_e;

  localparam logic [1:0] DIFF_EASY   = 2'd0;
  localparam logic [1:0] DIFF_MED    = 2'd1;
  localparam logic [1:0] DIFF_HARD   = 2'd2;
  localparam logic [1:0] DIFF_INSANE = 2'd3;

  // Frames per step for a difficulty, divided down while turbo is held.
  // A period of zero would never terminate, so it is clamped to one frame.
  function automatic int period_sel(input logic [1:0] difficulty,
                                    input logic       turbo,
                                    input int         f_easy,
                                    input int         f_med,
                                    input int         f_hard,
                                    input int         f_insane,
                                    input int         shift);
    int p;
    case (difficulty)
      DIFF_EASY: p = f_easy;
      DIFF_MED:  p = f_med;
      DIFF_HARD: p = f_hard;
      default:   p = f_insane;
    endcase
    if (turbo) p = p >> shift;
    if (p < 1) p = 1;
    return p;
  endfunction

endpackage

// File: rtl/game_step_scheduler_if.sv
// Signal bundle between the step scheduler and its neighbours (VGA timing,
// menu, keyboard and rect_controller). The scheduler uses the master view.
interface game_step_scheduler_if;
  logic        vsync_in;
  logic        game_start;
  logic        menu_interrupt;
  logic [1:0]  difficulty_level;
  logic        turbo_button;
  logic        step_done;
  logic        step_req;
  logic        busy;
  logic        fault;
  logic [15:0] step_count;

  modport master (
    input  vsync_in,
    input  game_start,
    input  menu_interrupt,
    input  difficulty_level,
    input  turbo_button,
    input  step_done,
    output step_req,
    output busy,
    output fault,
    output step_count
  );

  modport slave (
    output vsync_in,
    output game_start,
    output menu_interrupt,
    output difficulty_level,
    output turbo_button,
    output step_done,
    input  step_req,
    input  busy,
    input  fault,
    input  step_count
  );
endinterface

// File: rtl/game_step_scheduler_frame_tick_gen.sv
// Registered rising-edge detector on vsync: one single-cycle tick per frame,
// asserted the cycle after vsync is first sampled high.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_d_q;
  logic tick_q;

  // Delay vsync by one cycle and register the 0->1 detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      vsync_d_q <= vsync_in;
      tick_q    <= vsync_in & ~vsync_d_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_step_scheduler.sv
// Snake game step scheduler: counts frames, issues step requests to the
// snake controller at a difficulty-dependent rate, pauses under the menu and
// raises a sticky fault when a request is never acknowledged.
module game_step_scheduler
  import snake_sched_pkg::*;
#(
  parameter int FRAMES_EASY   = 30,
  parameter int FRAMES_MED    = 20,
  parameter int FRAMES_HARD   = 12,
  parameter int FRAMES_INSANE = 6,
  parameter int TURBO_SHIFT   = 1,
  parameter int CNT_W         = 8,
  parameter int DONE_TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  game_step_scheduler_if.master bus
);

  localparam int TO_W = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [TO_W-1:0]  to_inc;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             step_req_q;
  logic             busy_q;
  logic             fault_q;
  logic             tick;
  logic [CNT_W-1:0] period;

  frame_tick_gen u_tick (
    .clk      (clk),
    .rst      (rst),
    .vsync_in (bus.vsync_in),
    .tick     (tick)
  );

  // Difficulty and turbo only matter at the moment a period is loaded.
  assign period = CNT_W'(period_sel(bus.difficulty_level, bus.turbo_button,
                                    FRAMES_EASY, FRAMES_MED, FRAMES_HARD,
                                    FRAMES_INSANE, TURBO_SHIFT));

  assign to_inc = to_q + 1'b1;

  // Next-state logic: frame countdown, pause, request handshake and timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.game_start && !bus.menu_interrupt) begin
          step_cnt_d = '0;
          cnt_d      = period;
          to_d       = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.game_start) begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_IDLE;
        end else if (bus.menu_interrupt) begin
          // A tick in the same cycle is dropped: the pause takes precedence.
          state_d = ST_PAUSED;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            to_d    = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_PAUSED: begin
        if (!bus.game_start) begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_IDLE;
        end else if (!bus.menu_interrupt) begin
          state_d = ST_WAIT;
        end
      end
      ST_REQ: begin
        if (!bus.game_start) begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_IDLE;
        end else if (bus.step_done) begin
          // The menu never aborts a pending request; it only decides where
          // the scheduler lands once the step has been acknowledged.
          if (step_cnt_q != 16'hFFFF) step_cnt_d = step_cnt_q + 16'd1;
          cnt_d   = period;
          to_d    = '0;
          state_d = bus.menu_interrupt ? ST_PAUSED : ST_WAIT;
        end else if (to_inc == TO_W'(DONE_TIMEOUT)) begin
          to_d    = '0;
          state_d = ST_FAULT;
        end else begin
          to_d = to_inc;
        end
      end
      ST_FAULT: begin
        if (!bus.game_start) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        to_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      step_cnt_q <= '0;
      step_req_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      step_cnt_q <= step_cnt_d;
      step_req_q <= (state_d == ST_REQ);
      busy_q     <= (state_d == ST_WAIT) || (state_d == ST_PAUSED) ||
                    (state_d == ST_REQ);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign bus.step_req   = step_req_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;
  assign bus.step_count = step_cnt_q;

endmodule

// File: doc/game_step_scheduler.md
Name: game_step_scheduler

Overview:
- Sequences the snake game datapath: decides when the snake controller advances one grid step, and handshakes with it.
- Counts VGA frames (vsync edges) and converts difficulty level and turbo button into a frames-per-step period.
- Issues step requests, pauses while the menu is open, and flags a fault if a step is never acknowledged.
- Sits on the 65 MHz domain between menu_display (game_start, menu_interrupt, difficulty_level), keyboard_driver_moving (turbo_button) and rect_controller (step_req/step_done).

Parameters:
FRAMES_EASY, 30, frames per step for difficulty 0
FRAMES_MED, 20, frames per step for difficulty 1
FRAMES_HARD, 12, frames per step for difficulty 2
FRAMES_INSANE, 6, frames per step for difficulty 3
TURBO_SHIFT, 1, right-shift applied to the period while turbo is active
CNT_W, 8, frame counter width
DONE_TIMEOUT, 65535, max clk cycles in REQ without step_done before fault

Ports:
clk  in  1  65 MHz pixel/system clock
rst  in  1  asynchronous, active-low reset
vsync_in  in  1  vsync from VGA pipeline, same clock domain
game_start  in  1  high while a game is running
menu_interrupt  in  1  high while the menu overlay is open
difficulty_level  in  2  0 easy .. 3 insane
turbo_button  in  1  speed-up request
step_done  in  1  step acknowledge from rect_controller
step_req  out  1  step request, held until acknowledged
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  sticky timeout flag
step_count  out  16  steps completed this game, saturating at 0xFFFF

Behaviour:
- Reset (rst=0, async): state IDLE; step_req=0, busy=0, fault=0, step_count=0; counters 0; vsync_d=0.
- Frame tick:
  - vsync_d registers vsync_in.
  - tick = vsync_in & ~vsync_d, registered, so tick is high the cycle after vsync_in was first sampled high.
  - Exactly one tick per 0->1 transition.
- Period load, computed at each load:
  - Base period selected by difficulty_level (0 EASY, 1 MED, 2 HARD, 3 INSANE).
  - If turbo_button=1, period = base >> TURBO_SHIFT.
  - If the result is 0, it is clamped to 1.
  - turbo_button and difficulty_level are sampled only at load, not mid-count.
- IDLE:
  - On game_start=1 and menu_interrupt=0: clear step_count, load period into frame counter, go to WAIT.
- WAIT:
  - Each tick decrements the counter.
  - A tick while counter==1 goes to REQ; step_req=1 from the next cycle.
  - menu_interrupt=1 goes to PAUSED and keeps the counter. If a tick arrives in the same cycle, the pause wins and the tick is not counted.
- PAUSED:
  - Ticks are ignored.
  - When menu_interrupt=0, return to WAIT with the remaining count.
- REQ:
  - step_req held high; timeout counter increments each cycle.
  - On step_done=1 (sampled while step_req=1), in the same edge:
    - step_req drops;
    - step_count increments (saturating);
    - period reloads;
    - next state is PAUSED if menu_interrupt=1, else WAIT.
  - menu_interrupt never aborts a pending request.
  - Timeout counter reaching DONE_TIMEOUT goes to FAULT: step_req=0, fault=1.
- FAULT:
  - fault stays 1 and no requests are issued.
  - game_start=0 goes to IDLE and clears fault.
- game_start=0 in WAIT/PAUSED/REQ goes to IDLE on the next edge: step_req=0, counters cleared, step_count retained until the next game start.
- step_done outside REQ is ignored; it neither counts nor alters state.
- busy is registered from the next state.
- Nominal latency: vsync rising at edge n, tick at n+1, step_req high at n+2 when that tick terminates the period.

Decomposition:
- Package snake_sched_pkg holds:
  - state encoding IDLE/WAIT/PAUSED/REQ/FAULT;
  - difficulty codes DIFF_EASY..DIFF_INSANE;
  - function period_sel(difficulty, turbo), returning the clamped period.
- One sub-module frame_tick_gen (clk, rst, vsync_in -> tick), the registered rising-edge detector, reusable by menu_display.

Test Plan:
- Reset mid-REQ (step_req=1, rst pulsed 0) -> step_req, busy, fault, step_count all 0 immediately; state IDLE after release.
- difficulty=0, turbo=0, game_start=1, rect_controller model acks in 1 cycle -> step_req rises 30 ticks after start, 2 cycles after the 30th vsync edge; step_count=1; next request exactly 30 frames later.
- difficulty=3, turbo=1 held -> period 3 (6>>1); with FRAMES_INSANE overridden to 1 and turbo -> period clamped to 1, one step per frame.
- menu_interrupt raised after 10 of 20 frames (difficulty 1), held 50 frames, released -> no request while paused; request 10 frames after release. Interrupt raised during REQ -> step_req held until step_done, then PAUSED.
- step_done never returned, DONE_TIMEOUT=100 override -> fault=1 and step_req=0 at cycle 100 of REQ; game_start=0 -> fault clears, IDLE.
- step_done pulsed in WAIT; tick coincident with menu_interrupt rise -> step_count unchanged and the counter not decremented.
